tlb_req_translator: RTL

Translates virtual-address DMA requests into physical-address DMA commands. It issues lookups to the TLB, splits each request at page boundaries, and suspends on a miss until the mapping controller signals that new mappings are loaded. It sits directly downstream of the TLB controller's lookup port and upstream of the host DMA command queue.

---
 rtl/tlb_req_translator.sv | 131 +++++++++++++
 1 files changed

// File: rtl/tlb_req_translator.sv
// tlb_req_translator: turns virtual-address DMA requests into page-bounded physical DMA commands,
// one TLB lookup per chunk, parking on a miss until the mapping controller reports new mappings.
module tlb_req_translator #(
    parameter int VADDR_BITS    = 48,
    parameter int PADDR_BITS    = 40,
    parameter int PG_BITS       = 12,
    parameter int TLB_ORDER     = 10,
    parameter int PID_BITS      = 6,
    parameter int LEN_BITS      = 28,
    parameter int TAG_BITS      = VADDR_BITS - TLB_ORDER - PG_BITS,
    parameter int PHY_BITS      = PADDR_BITS - PG_BITS,
    parameter int TLB_DATA_BITS = TAG_BITS + PID_BITS + 1 + 2 * PHY_BITS
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [VADDR_BITS-1:0]    req_vaddr,
    input  logic [LEN_BITS-1:0]      req_len,
    input  logic [PID_BITS-1:0]      req_pid,
    input  logic                     req_wr,
    output logic                     tlb_valid,
    output logic [VADDR_BITS-1:0]    tlb_addr,
    output logic [PID_BITS-1:0]      tlb_pid,
    output logic                     tlb_wr,
    input  logic                     tlb_hit,
    input  logic [TLB_DATA_BITS-1:0] tlb_data,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [PADDR_BITS-1:0]    cmd_paddr,
    output logic [PG_BITS:0]         cmd_len,
    output logic                     cmd_wr,
    output logic                     cmd_last,
    output logic                     pf_valid,
    input  logic                     pf_ready,
    output logic [VADDR_BITS-1:0]    pf_vaddr,
    output logic [PID_BITS-1:0]      pf_pid,
    output logic                     pf_wr,
    input  logic                     done_map
);
    localparam int PPN_LSB = TAG_BITS + PID_BITS + 1;
    localparam logic [PG_BITS:0] PG_SIZE = {1'b1, {PG_BITS{1'b0}}};

    typedef enum logic [2:0] {ST_IDLE, ST_LUP, ST_RESP, ST_SEND, ST_PF, ST_WAIT} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [VADDR_BITS-1:0] r_vaddr;
    logic [LEN_BITS-1:0]   r_len;
    logic [PID_BITS-1:0]   r_pid;
    logic                  r_wr;
    logic [PADDR_BITS-1:0] r_paddr;
    logic [PG_BITS:0]      r_chunk;
    logic                  r_last;
    logic [PG_BITS-1:0]    w_off;
    logic [PG_BITS:0]      w_room;
    logic [PG_BITS:0]      w_chunk;
    logic                  w_last;
    logic                  w_unused;

    assign w_off    = r_vaddr[PG_BITS-1:0];
    assign w_room   = PG_SIZE - {1'b0, w_off};
    assign w_chunk  = (r_len < LEN_BITS'(w_room)) ? r_len[PG_BITS:0] : w_room;
    assign w_last   = r_len == LEN_BITS'(w_chunk);
    assign w_unused = ^{tlb_data[TLB_DATA_BITS-1 -: PHY_BITS], tlb_data[PPN_LSB-1:0]};

    always_ff @(posedge aclk) begin
        if (!aresetn) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = (req_valid && req_len != '0) ? ST_LUP : ST_IDLE;
            ST_LUP:  w_next = ST_RESP;
            ST_RESP: w_next = tlb_hit ? ST_SEND : ST_PF;
            ST_SEND: w_next = cmd_ready ? (r_last ? ST_IDLE : ST_LUP) : ST_SEND;
            ST_PF:   w_next = pf_ready ? ST_WAIT : ST_PF;
            ST_WAIT: w_next = done_map ? ST_LUP : ST_WAIT;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = aresetn && (r_state == ST_IDLE);
        tlb_valid = r_state == ST_LUP;
        cmd_valid = r_state == ST_SEND;
        pf_valid  = r_state == ST_PF;
    end

    // Chunk results are captured once in ST_RESP so the command stays stable under backpressure.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_vaddr <= '0;
            r_len   <= '0;
            r_pid   <= '0;
            r_wr    <= 1'b0;
            r_paddr <= '0;
            r_chunk <= '0;
            r_last  <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && req_valid) begin
                r_vaddr <= req_vaddr;
                r_len   <= req_len;
                r_pid   <= req_pid;
                r_wr    <= req_wr;
            end
            if (r_state == ST_RESP && tlb_hit) begin
                r_paddr <= {tlb_data[PPN_LSB +: PHY_BITS], w_off};
                r_chunk <= w_chunk;
                r_last  <= w_last;
            end
            if (r_state == ST_SEND && cmd_ready) begin
                r_vaddr <= r_vaddr + VADDR_BITS'(r_chunk);
                r_len   <= r_len - LEN_BITS'(r_chunk);
            end
        end
    end

    assign tlb_addr  = r_vaddr;
    assign tlb_pid   = r_pid;
    assign tlb_wr    = r_wr;
    assign cmd_paddr = r_paddr;
    assign cmd_len   = r_chunk;
    assign cmd_wr    = r_wr;
    assign cmd_last  = r_last;
    assign pf_vaddr  = r_vaddr;
    assign pf_pid    = r_pid;
    assign pf_wr     = r_wr;
endmodule
